// File: rtl/llc_sched_pkg.sv
// Shared encodings for the LLC command scheduler: command and FSM enums, the queued request record
// and the per-port legality checks.
package llc_sched_pkg;

  localparam int CMDSIZE   = 4;
  localparam int ADDR_BITS = 32;

  typedef enum logic [CMDSIZE-1:0] {
    CMD_RD_DATA = 4'd0,
    CMD_WR_DATA = 4'd1,
    CMD_RD_INST = 4'd2,
    CMD_SNP_RD  = 4'd3,
    CMD_SNP_WR  = 4'd4,
    CMD_SNP_RFO = 4'd5,
    CMD_SNP_INV = 4'd6,
    CMD_CLEAR   = 4'd8,
    CMD_PRINT   = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [CMDSIZE-1:0]   cmd;
    logic [ADDR_BITS-1:0] addr;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic is_cpu_cmd(input logic [CMDSIZE-1:0] c);
    return (c == CMD_RD_DATA) || (c == CMD_WR_DATA) || (c == CMD_RD_INST) ||
           (c == CMD_CLEAR)   || (c == CMD_PRINT);
  endfunction

  function automatic logic is_snp_cmd(input logic [CMDSIZE-1:0] c);
    return (c == CMD_SNP_RD) || (c == CMD_SNP_WR) || (c == CMD_SNP_RFO) || (c == CMD_SNP_INV);
  endfunction

  // CLEAR and PRINT carry no address; the LLC sees zero for them.
  function automatic logic has_no_addr(input logic [CMDSIZE-1:0] c);
    return (c == CMD_CLEAR) || (c == CMD_PRINT);
  endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// Synchronous request FIFO; head visible the cycle after a push, full reflects pre-pop occupancy.
// Pushes while full and pops while empty are ignored.
module llc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/llc_cmd_scheduler.sv
// Snoop-priority CPU/snoop command scheduler feeding the LLC one command at a time; push at edge N
// issues from edge N+1. Optional grant/error counters under LLC_SCHED_STATS_EN.
module llc_cmd_scheduler
  import llc_sched_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SNP_BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_valid,
  output logic                 cpu_ready,
  input  logic [CMDSIZE-1:0]   cpu_cmd,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic                 snp_valid,
  output logic                 snp_ready,
  input  logic [CMDSIZE-1:0]   snp_cmd,
  input  logic [ADDR_BITS-1:0] snp_addr,
  output logic                 llc_valid,
  input  logic                 llc_ready,
  output logic [CMDSIZE-1:0]   llc_cmd,
  output logic [ADDR_BITS-1:0] llc_addr,
  input  logic                 llc_done,
  output logic                 cmd_err,
  output logic                 busy
`ifdef LLC_SCHED_STATS_EN
  ,
  output logic [31:0]          cpu_grants,
  output logic [31:0]          snp_grants,
  output logic [31:0]          err_count
`endif
);

  localparam int BW = $clog2(SNP_BURST_MAX + 1);

  state_e        state;
  state_e        ret_state;
  logic          draining;
  logic          cur_src_cpu;
  logic [BW-1:0] burst_cnt;
  logic          burst_hit;

  req_t cpu_in, snp_in, cpu_head, snp_head, win;
  logic cpu_empty, cpu_full, snp_empty, snp_full;
  logic cpu_hs, snp_hs, cpu_push, snp_push;
  logic pick_cpu, pick_snp, go_drain;

  // The snoop port stays closed for the whole drain sequence so CLEAR is not starved.
  assign cpu_ready = !cpu_full;
  assign snp_ready = !snp_full && !draining;

  assign cpu_hs   = cpu_valid && cpu_ready;
  assign snp_hs   = snp_valid && snp_ready;
  assign cpu_push = cpu_hs && is_cpu_cmd(cpu_cmd);
  assign snp_push = snp_hs && is_snp_cmd(snp_cmd);
  assign cpu_in   = {cpu_cmd, cpu_addr};
  assign snp_in   = {snp_cmd, snp_addr};

  llc_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_cpu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_push),
    .din   (cpu_in),
    .pop   (pick_cpu),
    .dout  (cpu_head),
    .empty (cpu_empty),
    .full  (cpu_full)
  );

  llc_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_snp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (snp_push),
    .din   (snp_in),
    .pop   (pick_snp),
    .dout  (snp_head),
    .empty (snp_empty),
    .full  (snp_full)
  );

  assign burst_hit = (burst_cnt == BW'(SNP_BURST_MAX));
  assign win       = pick_cpu ? cpu_head : snp_head;
  assign ret_state = draining ? ST_DRAIN : ST_IDLE;
  assign busy      = (state != ST_IDLE) || !cpu_empty || !snp_empty;

  always_comb begin
    pick_cpu = 1'b0;
    pick_snp = 1'b0;
    go_drain = 1'b0;
    if (state == ST_IDLE) begin
      if (!snp_empty && !(!cpu_empty && burst_hit)) begin
        pick_snp = 1'b1;
      end else if (!cpu_empty) begin
        if ((cpu_head.cmd == CMD_CLEAR) && !snp_empty) go_drain = 1'b1;
        else                                           pick_cpu = 1'b1;
      end
    end else if (state == ST_DRAIN) begin
      // Only CLEAR can be at the CPU head here; it goes once snoops are gone.
      if (!snp_empty)      pick_snp = 1'b1;
      else if (!cpu_empty) pick_cpu = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      llc_valid   <= 1'b0;
      llc_cmd     <= '0;
      llc_addr    <= '0;
      cmd_err     <= 1'b0;
      draining    <= 1'b0;
      cur_src_cpu <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      cmd_err <= (cpu_hs && !is_cpu_cmd(cpu_cmd)) || (snp_hs && !is_snp_cmd(snp_cmd));

      if (cpu_empty || pick_cpu)               burst_cnt <= '0;
      else if (pick_snp && !burst_hit)         burst_cnt <= burst_cnt + BW'(1);

      case (state)
        ST_IDLE, ST_DRAIN: begin
          if (pick_cpu || pick_snp) begin
            state       <= ST_ISSUE;
            llc_valid   <= 1'b1;
            llc_cmd     <= win.cmd;
            llc_addr    <= has_no_addr(win.cmd) ? '0 : win.addr;
            cur_src_cpu <= pick_cpu;
            if (pick_cpu) draining <= 1'b0;
          end else if (go_drain) begin
            state    <= ST_DRAIN;
            draining <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (llc_ready) begin
            llc_valid <= 1'b0;
            state     <= llc_done ? ret_state : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (llc_done) state <= ret_state;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LLC_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_grants <= '0;
      snp_grants <= '0;
      err_count  <= '0;
    end else begin
      if (state == ST_ISSUE && llc_ready) begin
        if (cur_src_cpu) begin
          if (cpu_grants != '1) cpu_grants <= cpu_grants + 32'd1;
        end else if (snp_grants != '1) begin
          snp_grants <= snp_grants + 32'd1;
        end
      end
      if (cmd_err && err_count != '1) err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_cmd_scheduler.sv
// Randomised and directed bench for llc_cmd_scheduler against a queue-level reference model.
module tb_llc_cmd_scheduler;

  localparam int FD  = 4;
  localparam int SBM = 4;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
  } ent_t;

  logic        clk, rst;
  logic        cpu_valid, cpu_ready, snp_valid, snp_ready;
  logic [3:0]  cpu_cmd, snp_cmd, llc_cmd;
  logic [31:0] cpu_addr, snp_addr, llc_addr;
  logic        llc_valid, llc_ready, llc_done, cmd_err, busy;
`ifdef LLC_SCHED_STATS_EN
  logic [31:0] cpu_grants, snp_grants, err_count;
`endif

  llc_cmd_scheduler #(.FIFO_DEPTH(FD), .SNP_BURST_MAX(SBM)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_cmd   (cpu_cmd),
    .cpu_addr  (cpu_addr),
    .snp_valid (snp_valid),
    .snp_ready (snp_ready),
    .snp_cmd   (snp_cmd),
    .snp_addr  (snp_addr),
    .llc_valid (llc_valid),
    .llc_ready (llc_ready),
    .llc_cmd   (llc_cmd),
    .llc_addr  (llc_addr),
    .llc_done  (llc_done),
    .cmd_err   (cmd_err),
    .busy      (busy)
`ifdef LLC_SCHED_STATS_EN
    ,
    .cpu_grants(cpu_grants),
    .snp_grants(snp_grants),
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: two queues plus "LLC owned / presented / draining" flags.
  ent_t q_cpu[$];
  ent_t q_snp[$];
  ent_t m_cur;
  bit   m_out, m_pres, m_drain, m_src_cpu, m_err;
  int   m_burst, m_cg, m_sg, m_ec;

  logic [3:0]  acc_cmd[$];
  logic [31:0] acc_addr[$];
  logic        acc_srdy[$];

  function automatic bit cpu_ok(input logic [3:0] c);
    return (c <= 4'd2) || (c == 4'd8) || (c == 4'd9);
  endfunction

  function automatic bit snp_ok(input logic [3:0] c);
    return (c >= 4'd3) && (c <= 4'd6);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_cpu.delete();
    q_snp.delete();
    m_cur = '0;
    m_out = 0; m_pres = 0; m_drain = 0; m_src_cpu = 0; m_err = 0;
    m_burst = 0; m_cg = 0; m_sg = 0; m_ec = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare every output.
  task automatic step();
    bit   cr, sr, gc, gs;
    ent_t e;
    if (llc_valid && llc_ready) begin
      acc_cmd.push_back(llc_cmd);
      acc_addr.push_back(llc_addr);
      acc_srdy.push_back(snp_ready);
    end
    @(posedge clk);
    cr = (q_cpu.size() < FD);
    sr = (q_snp.size() < FD) && !m_drain;
    gc = 0; gs = 0; e = '0;
    if (!m_out) begin
      if (m_drain) begin
        if (q_snp.size() > 0)      gs = 1;
        else if (q_cpu.size() > 0) gc = 1;
      end else if (q_snp.size() > 0 && !(q_cpu.size() > 0 && m_burst == SBM)) begin
        gs = 1;
      end else if (q_cpu.size() > 0) begin
        if (q_cpu[0].c == 4'd8 && q_snp.size() > 0) m_drain = 1;
        else                                         gc = 1;
      end
    end else if (m_pres) begin
      if (llc_ready) begin
        m_pres = 0;
        if (m_src_cpu) m_cg++; else m_sg++;
        if (llc_done) m_out = 0;
      end
    end else if (llc_done) begin
      m_out = 0;
    end
    if (q_cpu.size() == 0 || gc) m_burst = 0;
    else if (gs && m_burst < SBM) m_burst++;
    if (gs) e = q_snp.pop_front();
    if (gc) begin
      e = q_cpu.pop_front();
      m_drain = 0;
    end
    if (gs || gc) begin
      m_cur = e;
      if (e.c == 4'd8 || e.c == 4'd9) m_cur.a = '0;
      m_out = 1; m_pres = 1; m_src_cpu = gc;
    end
    if (m_err) m_ec++;
    m_err = (cpu_valid && cr && !cpu_ok(cpu_cmd)) || (snp_valid && sr && !snp_ok(snp_cmd));
    if (cpu_valid && cr && cpu_ok(cpu_cmd)) q_cpu.push_back({cpu_cmd, cpu_addr});
    if (snp_valid && sr && snp_ok(snp_cmd)) q_snp.push_back({snp_cmd, snp_addr});
    #1;
    chk("llc_valid", 64'(llc_valid), 64'(m_pres));
    if (m_pres) begin
      chk("llc_cmd", 64'(llc_cmd), 64'(m_cur.c));
      chk("llc_addr", 64'(llc_addr), 64'(m_cur.a));
    end
    chk("cpu_ready", 64'(cpu_ready), 64'(q_cpu.size() < FD));
    chk("snp_ready", 64'(snp_ready), 64'((q_snp.size() < FD) && !m_drain));
    chk("busy", 64'(busy), 64'(m_out || m_drain || q_cpu.size() > 0 || q_snp.size() > 0));
    chk("cmd_err", 64'(cmd_err), 64'(m_err));
`ifdef LLC_SCHED_STATS_EN
    chk("cpu_grants", 64'(cpu_grants), 64'(m_cg));
    chk("snp_grants", 64'(snp_grants), 64'(m_sg));
    chk("err_count", 64'(err_count), 64'(m_ec));
`endif
  endtask

  task automatic idle_inputs();
    cpu_valid = 0; cpu_cmd = '0; cpu_addr = '0;
    snp_valid = 0; snp_cmd = '0; snp_addr = '0;
    llc_ready = 0; llc_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Six snoop cmd 4 plus one CPU command, with the LLC stalled until the FIFOs are loaded.
  task automatic run_order(input logic [3:0] ccmd, input logic [31:0] caddr);
    int sn;
    bit cdone, cp, sp;
    do_reset();
    acc_cmd.delete(); acc_addr.delete(); acc_srdy.delete();
    sn = 0; cdone = 0;
    for (int i = 0; i < 200 && acc_cmd.size() < 7; i++) begin
      cpu_valid = !cdone; cpu_cmd = ccmd; cpu_addr = caddr;
      snp_valid = (sn < 6); snp_cmd = 4'd4; snp_addr = 32'h2000 + 32'(sn * 64);
      llc_ready = (i >= 6); llc_done = (i >= 6);
      cp = cpu_valid && cpu_ready;
      sp = snp_valid && snp_ready;
      step();
      if (cp) cdone = 1;
      if (sp) sn++;
    end
    idle_inputs();
    repeat (2) step();
    chk("order_count", 64'(acc_cmd.size()), 64'd7);
  endtask

  logic [3:0] exp_ord [7];
  logic [3:0] cpu_pool [12];
  logic [3:0] snp_pool [10];

  initial begin
    cpu_pool = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd8, 4'd7, 4'd3, 4'd15};
    snp_pool = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2, 4'd7};

    // Reset values
    do_reset();
    chk("rst_llc_valid", 64'(llc_valid), 64'd0);
    chk("rst_llc_cmd", 64'(llc_cmd), 64'd0);
    chk("rst_llc_addr", 64'(llc_addr), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_ready", 64'(cpu_ready), 64'd1);
    chk("rst_snp_ready", 64'(snp_ready), 64'd1);
`ifdef LLC_SCHED_STATS_EN
    chk("rst_err_count", 64'(err_count), 64'd0);
`endif

    // Single CPU read: issue one cycle after push, busy drops after done
    llc_ready = 1;
    cpu_valid = 1; cpu_cmd = 4'd0; cpu_addr = 32'h1000;
    step();
    cpu_valid = 0;
    chk("lat_before_grant", 64'(llc_valid), 64'd0);
    step();
    chk("lat_valid", 64'(llc_valid), 64'd1);
    chk("lat_cmd", 64'(llc_cmd), 64'd0);
    chk("lat_addr", 64'(llc_addr), 64'h1000);
    step();
    chk("lat_accepted", 64'(llc_valid), 64'd0);
    chk("lat_busy_wait", 64'(busy), 64'd1);
    llc_done = 1;
    step();
    llc_done = 0;
    chk("lat_busy_done", 64'(busy), 64'd0);

    // Illegal commands on both ports
    do_reset();
    cpu_valid = 1; cpu_cmd = 4'd7; cpu_addr = 32'h40;
    chk("ill_cpu_ready", 64'(cpu_ready), 64'd1);
    step();
    cpu_valid = 0;
    chk("ill_err1", 64'(cmd_err), 64'd1);
    step();
    chk("ill_err1_end", 64'(cmd_err), 64'd0);
    snp_valid = 1; snp_cmd = 4'd2; snp_addr = 32'h80;
    chk("ill_snp_ready", 64'(snp_ready), 64'd1);
    step();
    snp_valid = 0;
    chk("ill_err2", 64'(cmd_err), 64'd1);
    step();
    chk("ill_err2_end", 64'(cmd_err), 64'd0);
    chk("ill_no_issue", 64'(llc_valid), 64'd0);
    chk("ill_idle", 64'(busy), 64'd0);

    // Burst limit: S,S,S,S,C,S,S
    exp_ord = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd1, 4'd4, 4'd4};
    run_order(4'd1, 32'h3000);
    for (int k = 0; k < 7; k++)
      if (k < acc_cmd.size()) chk($sformatf("order_%0d", k), 64'(acc_cmd[k]), 64'(exp_ord[k]));
`ifdef LLC_SCHED_STATS_EN
    chk("stats_snp_grants", 64'(snp_grants), 64'd6);
    chk("stats_cpu_grants", 64'(cpu_grants), 64'd1);
`endif

    // CLEAR reaching the burst limit drains the remaining snoops first
    exp_ord = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd8};
    run_order(4'd8, 32'hDEAD);
    for (int k = 0; k < 7; k++)
      if (k < acc_cmd.size()) chk($sformatf("drain_%0d", k), 64'(acc_cmd[k]), 64'(exp_ord[k]));
    if (acc_cmd.size() == 7) begin
      chk("drain_clear_addr", 64'(acc_addr[6]), 64'd0);
      chk("drain_snp_rdy5", 64'(acc_srdy[4]), 64'd0);
      chk("drain_snp_rdy6", 64'(acc_srdy[5]), 64'd0);
    end

    // Fill CPU FIFO behind a stalled LLC, then reset mid-ISSUE
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cpu_valid = 1; cpu_cmd = 4'd1; cpu_addr = 32'(i * 16);
      step();
    end
    cpu_valid = 0;
    chk("fill_cpu_ready", 64'(cpu_ready), 64'd0);
    chk("fill_llc_valid", 64'(llc_valid), 64'd1);
    #3 rst = 1;
    #1;
    chk("midrst_llc_valid", 64'(llc_valid), 64'd0);
    chk("midrst_cpu_ready", 64'(cpu_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cpu_valid = ($urandom_range(0, 1) == 1);
      cpu_cmd   = cpu_pool[$urandom_range(0, 11)];
      cpu_addr  = $urandom;
      snp_valid = ($urandom_range(0, 3) != 0);
      snp_cmd   = snp_pool[$urandom_range(0, 9)];
      snp_addr  = $urandom;
      llc_ready = ($urandom_range(0, 3) != 0);
      llc_done  = ($urandom_range(0, 2) == 0);
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
